// File: rtl/updown_seq_monitor.sv
// Receive-side checker for a bouncing up/down counter stream
// (0,1,..,MAX,MAX,MAX-1,..,0,0,1,..). Locks onto the stream, reports
// direction and peak/valley events, counts periods and flags breaks.
// Optional feature macro: UDMON_ERRCNT_EN adds a saturating err_count output.
module updown_seq_monitor #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  sample,
  output logic              locked,
  output logic              dir,
  output logic              peak_pulse,
  output logic              valley_pulse,
  output logic              err_pulse,
  output logic [PCNT_W-1:0] period_count
`ifdef UDMON_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned ECNT_W = 8;
  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_ACQ,
    ST_SYNC,
    ST_UP,
    ST_TOP,
    ST_DOWN,
    ST_BOT
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                locked_q, locked_d;
  logic                dir_q, dir_d;
  logic                peak_q, peak_d;
  logic                valley_q, valley_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    p_inc, p_dec;
  logic                at_max, at_zero, mismatch;

  // Neighbour values of prev; wrap cases are excluded via at_max/at_zero
  assign p_inc   = prev_q + WIDTH'(1);
  assign p_dec   = prev_q - WIDTH'(1);
  assign at_max  = (prev_q == MaxVal);
  assign at_zero = (prev_q == '0);

  // State register and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ACQ;
      prev_q   <= '0;
      pcnt_q   <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      peak_q   <= 1'b0;
      valley_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pcnt_q   <= pcnt_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      peak_q   <= peak_d;
      valley_q <= valley_d;
      err_q    <= err_d;
    end
  end

  // Next-state, sequence checking and event generation
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    pcnt_d   = pcnt_q;
    peak_d   = 1'b0;
    valley_d = 1'b0;
    err_d    = 1'b0;
    mismatch = 1'b0;
    if (sample_valid) begin
      prev_d = sample;
      case (state_q)
        ST_ACQ: state_d = ST_SYNC;
        ST_SYNC: begin
          if (!at_max && sample == p_inc) begin
            state_d = (sample == MaxVal) ? ST_TOP : ST_UP;
          end else if (!at_zero && sample == p_dec) begin
            state_d = (sample == '0) ? ST_BOT : ST_DOWN;
          end else if (at_max && sample == MaxVal) begin
            state_d = ST_DOWN;
          end else if (at_zero && sample == '0) begin
            state_d = ST_UP;
          end
        end
        ST_UP: begin
          if (!at_max && sample == p_inc) begin
            state_d = (sample == MaxVal) ? ST_TOP : ST_UP;
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_TOP: begin
          if (sample == MaxVal) begin
            state_d = ST_DOWN;
            peak_d  = 1'b1;
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_DOWN: begin
          if (!at_zero && sample == p_dec) begin
            state_d = (sample == '0) ? ST_BOT : ST_DOWN;
          end else begin
            mismatch = 1'b1;
          end
        end
        ST_BOT: begin
          if (sample == '0) begin
            state_d  = ST_UP;
            valley_d = 1'b1;
            pcnt_d   = pcnt_q + PCNT_W'(1);
          end else begin
            mismatch = 1'b1;
          end
        end
        default: state_d = ST_ACQ;
      endcase
      // A break drops lock; relock needs at least one more sample
      if (mismatch) begin
        state_d = ST_SYNC;
        err_d   = 1'b1;
      end
    end
    locked_d = (state_d == ST_UP) || (state_d == ST_TOP) ||
               (state_d == ST_DOWN) || (state_d == ST_BOT);
    dir_d    = (state_d == ST_DOWN) || (state_d == ST_BOT);
  end

  assign locked       = locked_q;
  assign dir          = dir_q;
  assign peak_pulse   = peak_q;
  assign valley_pulse = valley_q;
  assign err_pulse    = err_q;
  assign period_count = pcnt_q;

`ifdef UDMON_ERRCNT_EN
  logic [ECNT_W-1:0] ecnt_q, ecnt_d;

  // Saturating mismatch counter, cleared only by reset
  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d && ecnt_q != {ECNT_W{1'b1}}) begin
      ecnt_d = ecnt_q + ECNT_W'(1);
    end
  end

  // Error counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign err_count = ecnt_q;
`endif

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Directed bench for updown_seq_monitor; err_count checks apply when
// UDMON_ERRCNT_EN is defined.
module tb_updown_seq_monitor;

  logic       clock;
  logic       reset;
  logic       sample_valid;
  logic [3:0] sample;
  logic       locked;
  logic       dir;
  logic       peak_pulse;
  logic       valley_pulse;
  logic       err_pulse;
  logic [7:0] period_count;
`ifdef UDMON_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  updown_seq_monitor #(.WIDTH(4), .PCNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .locked       (locked),
    .dir          (dir),
    .peak_pulse   (peak_pulse),
    .valley_pulse (valley_pulse),
    .err_pulse    (err_pulse),
    .period_count (period_count)
`ifdef UDMON_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one input for one clock edge, then settle past the edge
  task automatic step(input logic v, input logic [3:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".locked"}, 32'(locked), 0);
    check_eq({tag, ".dir"}, 32'(dir), 0);
    check_eq({tag, ".peak"}, 32'(peak_pulse), 0);
    check_eq({tag, ".valley"}, 32'(valley_pulse), 0);
    check_eq({tag, ".err"}, 32'(err_pulse), 0);
    check_eq({tag, ".pcnt"}, 32'(period_count), 0);
`ifdef UDMON_ERRCNT_EN
    check_eq({tag, ".ecnt"}, 32'(err_count), 0);
`endif
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    sample       = 4'd0;
    reset        = 1'b1;
    #3;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Clean 34-sample stream; optional 3-cycle valid gap after sample hold_at
  task automatic run_stream(input int hold_at);
    int v;
    for (int i = 0; i < 34; i++) begin
      v = (i < 16) ? i : (i < 32) ? 31 - i : i - 32;
      step(1'b1, 4'(v));
      check_eq("str.locked", 32'(locked), (i >= 1) ? 1 : 0);
      check_eq("str.dir", 32'(dir), (i >= 16 && i <= 31) ? 1 : 0);
      check_eq("str.peak", 32'(peak_pulse), (i == 16) ? 1 : 0);
      check_eq("str.valley", 32'(valley_pulse), (i == 32) ? 1 : 0);
      check_eq("str.err", 32'(err_pulse), 0);
      check_eq("str.pcnt", 32'(period_count), (i >= 32) ? 1 : 0);
      if (i == hold_at) begin
        for (int k = 0; k < 3; k++) begin
          step(1'b0, 4'(3 + k));
          check_eq("hold.locked", 32'(locked), 1);
          check_eq("hold.dir", 32'(dir), (i >= 16 && i <= 31) ? 1 : 0);
          check_eq("hold.peak", 32'(peak_pulse), 0);
          check_eq("hold.valley", 32'(valley_pulse), 0);
          check_eq("hold.err", 32'(err_pulse), 0);
        end
      end
    end
  endtask

  initial begin
    int errs;
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample       = 4'd0;
    #1;

    // Clean stream
    do_reset();
    run_stream(-1);

    // Valid gap mid-ramp (after sample 8, while UP) and mid-descent
    do_reset();
    run_stream(8);
    do_reset();
    run_stream(20);

    // Break while UP: 7 then 9
    do_reset();
    for (int i = 0; i <= 7; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd9);
    check_eq("upbrk.err", 32'(err_pulse), 1);
    check_eq("upbrk.locked", 32'(locked), 0);
`ifdef UDMON_ERRCNT_EN
    check_eq("upbrk.ecnt", 32'(err_count), 1);
`endif
    step(1'b1, 4'd10);
    check_eq("upbrk.relock10", 32'(locked), 1);
    check_eq("upbrk.err10", 32'(err_pulse), 0);
    step(1'b1, 4'd11);
    check_eq("upbrk.locked11", 32'(locked), 1);
    check_eq("upbrk.dir11", 32'(dir), 0);

    // Break at TOP: 14 instead of second 15, then 13 relocks down
    do_reset();
    for (int i = 0; i <= 15; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd14);
    check_eq("topbrk.err", 32'(err_pulse), 1);
    check_eq("topbrk.peak", 32'(peak_pulse), 0);
    check_eq("topbrk.locked", 32'(locked), 0);
    step(1'b1, 4'd13);
    check_eq("topbrk.locked13", 32'(locked), 1);
    check_eq("topbrk.dir13", 32'(dir), 1);
    check_eq("topbrk.err13", 32'(err_pulse), 0);

    // Wrap 15->0 in UP is an error; 0->15 at BOT is an error
    do_reset();
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    check_eq("zz.locked", 32'(locked), 1);
    check_eq("zz.dir", 32'(dir), 0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd0);
    check_eq("updown.err", 32'(err_pulse), 1);
    step(1'b1, 4'd15);
    check_eq("sync0to15.locked", 32'(locked), 0);
    check_eq("sync0to15.err", 32'(err_pulse), 0);
    step(1'b1, 4'd15);
    check_eq("mm.locked", 32'(locked), 1);
    check_eq("mm.dir", 32'(dir), 1);
    check_eq("mm.peak", 32'(peak_pulse), 0);
    step(1'b1, 4'd14);
    step(1'b1, 4'd15);
    check_eq("dnwrap.err", 32'(err_pulse), 1);
    check_eq("dnwrap.locked", 32'(locked), 0);
    step(1'b1, 4'd14);
    for (int i = 13; i >= 0; i--) step(1'b1, 4'(i));
    check_eq("bot.dir", 32'(dir), 1);
    step(1'b1, 4'd15);
    check_eq("botbrk.err", 32'(err_pulse), 1);
    check_eq("botbrk.valley", 32'(valley_pulse), 0);
    check_eq("botbrk.pcnt", 32'(period_count), 0);

    // Async reset mid-DOWN after one full period
    do_reset();
    run_stream(-1);
    for (int i = 2; i <= 15; i++) step(1'b1, 4'(i));
    step(1'b1, 4'd15);
    step(1'b1, 4'd14);
    check_eq("pre_rst.dir", 32'(dir), 1);
    check_eq("pre_rst.pcnt", 32'(period_count), 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    reset = 1'b0;
    step(1'b1, 4'd5);
    check_eq("acq.locked", 32'(locked), 0);
    step(1'b1, 4'd6);
    check_eq("acq.relock", 32'(locked), 1);
    check_eq("acq.pcnt", 32'(period_count), 0);

    // 300 errors: alternate 4 (relock UP from 3) and 3 (break)
    do_reset();
    step(1'b1, 4'd3);
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'd4);
      if (err_pulse) errs++;
      step(1'b1, 4'd3);
      if (err_pulse) errs++;
    end
    check_eq("sat.err_pulses", 32'(errs), 300);
    check_eq("sat.locked", 32'(locked), 0);
`ifdef UDMON_ERRCNT_EN
    check_eq("sat.ecnt", 32'(err_count), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
